arb_mux_rr: RTL and testbench

//   Registered N-channel operand/request multiplexer with a valid/ready handshake. It replaces the

---
 rtl/arb_mux_rr.sv | 136 +++++++++++++
 tb/tb_arb_mux_rr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: registered N-channel request mux with valid/ready handshake.
// Fixed-select (mode=1) or round-robin (mode=0) grant, one output register.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_data           N channels of WIDTH bits, ch i at [i*WIDTH +: WIDTH]
//   in_valid/ready    per-channel handshake
//   mode, sel         0 = round-robin, 1 = fixed channel sel
//   flush             drop the output item, accept nothing this cycle
//   out_data/src      registered item and the channel it came from
//   out_valid/ready   output handshake
module arb_mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 5,
  parameter int SELW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_src;
  logic [SELW-1:0]   r_ptr;

  logic [WIDTH-1:0]  w_ch [N];
  logic              w_rr_hit;
  logic [SELW-1:0]   w_rr_idx;
  logic              w_fx_hit;
  logic              w_gnt_hit;
  logic [SELW-1:0]   w_gnt_idx;
  logic              w_accept;
  logic              w_take;
  logic [SELW:0]     w_cand;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_ch[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin: search ptr+1, ptr+2, ... wrapping modulo N.
  // The extra bit in w_cand holds ptr+k before the wrap.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_cand   = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = {1'b0, r_ptr} + (SELW+1)'(k);
      if (w_cand >= (SELW+1)'(N)) begin
        w_cand = w_cand - (SELW+1)'(N);
      end
      if (!w_rr_hit && in_valid[w_cand[SELW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand[SELW-1:0];
      end
    end
  end

  // Out-of-range sel grants nothing.
  always_comb begin
    w_fx_hit = 1'b0;
    if (int'(sel) < N) begin
      w_fx_hit = in_valid[sel];
    end
  end

  always_comb begin
    w_gnt_hit = 1'b0;
    w_gnt_idx = '0;
    unique case (1'b1)
      mode: begin
        w_gnt_hit = w_fx_hit;
        w_gnt_idx = sel;
      end
      !mode: begin
        w_gnt_hit = w_rr_hit;
        w_gnt_idx = w_rr_idx;
      end
      default: begin
        w_gnt_hit = 1'b0;
        w_gnt_idx = '0;
      end
    endcase
  end

  assign w_accept = !flush && (r_state == EMPTY || out_ready);
  assign w_take   = w_accept && w_gnt_hit;

  always_comb begin
    in_ready = '0;
    if (rst_n && w_take) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SELW'(N-1);
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (w_take) begin
      r_state <= FULL;
      r_data  <= w_ch[w_gnt_idx];
      r_src   <= w_gnt_idx;
      if (!mode) begin
        r_ptr <= w_gnt_idx;
      end
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed bench with a behavioural reference model.
// Model compared every negedge; literal checks pin key points.
module tb_arb_mux_rr;

  localparam int W = 16;
  localparam int N = 5;
  localparam int S = 3;

  logic             clk;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [S-1:0]     sel;
  logic             flush;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_src;
  logic             out_valid;
  logic             out_ready;

  arb_mux_rr #(.WIDTH(W), .N(N), .SELW(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .flush     (flush),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] ch [N];

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;
  int           m_g;
  bit           m_acc;
  logic [N-1:0] m_rdy;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int model_grant();
    int i;
    if (mode) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) return int'(sel);
      end
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      i = (m_ptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = N - 1;
    end
    chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
    chk("mdl_out_data", 32'(out_data), 32'(m_data));
    chk("mdl_out_src", 32'(out_src), m_src);
    m_g   = model_grant();
    m_acc = rst_n && !flush && (!m_valid || out_ready);
    m_rdy = '0;
    if (m_acc && m_g >= 0) m_rdy[m_g] = 1'b1;
    chk("mdl_in_ready", 32'(in_ready), 32'(m_rdy));
    if (rst_n) begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (m_acc && m_g >= 0) begin
        m_valid = 1'b1;
        m_data  = ch[m_g];
        m_src   = m_g;
        if (!mode) m_ptr = m_g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int seq5 [4];

  initial begin
    ch[0] = 16'hABCD;
    ch[1] = 16'h0123;
    ch[2] = 16'h0000;
    ch[3] = 16'h4567;
    ch[4] = 16'h89EF;
    in_data   = {16'h89EF, 16'h4567, 16'h0000, 16'h0123, 16'hABCD};
    rst_n     = 1'b0;
    in_valid  = 5'b11111;
    mode      = 1'b1;
    sel       = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    seq5      = '{3, 1, 3, 1};

    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    for (int s = 0; s < N; s++) begin
      sel = S'(s);
      tick();
      chk("t1_data", 32'(out_data), 32'(ch[s]));
      chk("t1_src", 32'(out_src), s);
      chk("t1_valid", 32'(out_valid), 32'h1);
    end

    sel = 3'd5;
    tick();
    chk("t2_sel5_valid", 32'(out_valid), 32'h0);
    chk("t2_sel5_rdy", 32'(in_ready), 32'h0);
    sel = 3'd7;
    tick();
    chk("t2_sel7_valid", 32'(out_valid), 32'h0);
    chk("t2_sel7_rdy", 32'(in_ready), 32'h0);
    sel = 3'd2;
    in_valid = 5'b11011;
    #1;
    chk("t2_inv2_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("t2_inv2_valid", 32'(out_valid), 32'h0);

    mode = 1'b0;
    in_valid = 5'b11111;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t3_src", 32'(out_src), i % N);
      chk("t3_rdy", 32'(in_ready), 32'(1 << ((i + 1) % N)));
    end

    out_ready = 1'b0;
    do_reset();
    tick();
    chk("t4_first", 32'(out_data), 32'hABCD);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_data", 32'(out_data), 32'hABCD);
      chk("t4_hold_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_next_data", 32'(out_data), 32'h0123);
    chk("t4_next_valid", 32'(out_valid), 32'h1);

    in_valid = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_alt_src", 32'(out_src), seq5[i]);
    end
    in_valid = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_one_src", 32'(out_src), 32'h1);
      chk("t5_one_valid", 32'(out_valid), 32'h1);
    end

    mode = 1'b1;
    sel = 3'd3;
    in_valid = 5'b11111;
    tick();
    chk("t6_full", 32'(out_data), 32'h4567);
    flush = 1'b1;
    #1;
    chk("t6_flush_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("t6_flush_valid", 32'(out_valid), 32'h0);
    flush = 1'b0;
    mode = 1'b0;
    tick();
    chk("t6_ptr_kept", 32'(out_src), 32'h2);
    chk("t6_ptr_data", 32'(out_data), 32'h0000);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(out_valid), 32'h0);
    chk("t6_arst_data", 32'(out_data), 32'h0);
    chk("t6_arst_src", 32'(out_src), 32'h0);
    chk("t6_arst_rdy", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_src", 32'(out_src), 32'h0);
    chk("t6_post_data", 32'(out_data), 32'hABCD);
    tick();
    chk("t6_post2_src", 32'(out_src), 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
